// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: collects A, B and opcode bytes and drives the combinational ALU's one-hot OpDec for a fixed settle window
// Ports: clk, reset_n (async, active low); start, abort control; data_in/data_valid/data_ready byte handshake;
// A, B registered operands; OpDec one-hot opcode (0 = no op); busy, done pulse, sticky op_err, op_count completions.
module alu_operand_sequencer #(
  parameter int DATA_W      = 8,
  parameter int OPDEC_W     = 16,
  parameter int NUM_OPS     = 9,
  parameter int HOLD_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic [DATA_W-1:0]  data_in,
  input  logic               data_valid,
  output logic               data_ready,
  output logic [DATA_W-1:0]  A,
  output logic [DATA_W-1:0]  B,
  output logic [OPDEC_W-1:0] OpDec,
  output logic               busy,
  output logic               done,
  output logic               op_err,
  output logic [7:0]         op_count
);
  localparam int CW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  typedef enum logic [2:0] {IDLE, GET_A, GET_B, GET_OP, DRIVE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [3:0] op;
  logic xfer, legal, last, fin;
  // abort blocks capture of a byte arriving in the same cycle
  assign xfer  = data_valid && data_ready && !abort;
  assign op    = data_in[3:0];
  assign legal = 32'(op) < NUM_OPS;
  assign last  = state == DRIVE && cnt == CW'(HOLD_CYCLES - 1);
  assign fin   = last && !abort;
  always_comb begin
    state_nx = state;
    if (abort) state_nx = IDLE;
    else
      case (state)
        IDLE:    state_nx = start ? GET_A : IDLE;
        GET_A:   state_nx = xfer ? GET_B : GET_A;
        GET_B:   state_nx = xfer ? GET_OP : GET_B;
        GET_OP:  state_nx = xfer ? (legal ? DRIVE : IDLE) : GET_OP;
        DRIVE:   state_nx = last ? IDLE : DRIVE;
        default: state_nx = IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  // outputs are registered from the next state so they line up with it
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      A          <= '0;
      B          <= '0;
      OpDec      <= '0;
      op_count   <= '0;
      data_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      op_err     <= 1'b0;
      cnt        <= '0;
    end else begin
      data_ready <= state_nx inside {GET_A, GET_B, GET_OP};
      busy       <= state_nx != IDLE;
      done       <= fin;
      cnt        <= state == DRIVE ? cnt + CW'(1) : '0;
      if (fin) op_count <= op_count + 8'd1;
      if (xfer && state == GET_A) A <= data_in;
      if (xfer && state == GET_B) B <= data_in;
      if (abort) OpDec <= '0;
      else if (state == IDLE && start) begin
        OpDec  <= '0;
        op_err <= 1'b0;
      end else if (xfer && state == GET_OP) begin
        if (legal) OpDec <= OPDEC_W'(1) << op;
        else op_err <= 1'b1;
      end
    end
endmodule

// File: tb/tb_alu_operand_sequencer.sv
// tb_alu_operand_sequencer: randomized transaction-level check of alu_operand_sequencer
module tb_alu_operand_sequencer;
  logic clk = 1'b0;
  logic reset_n, start, abort, data_valid, data_ready, busy, done, op_err;
  logic [7:0] data_in, A, B, op_count;
  logic [15:0] OpDec;
  int n_chk, n_pass;
  logic [7:0] m_a, m_b;
  logic [15:0] m_opdec;
  int m_cnt;

  alu_operand_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
    .A(A), .B(B), .OpDec(OpDec), .busy(busy), .done(done),
    .op_err(op_err), .op_count(op_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [15:0] onehot(input int op);
    return 16'(2 ** op);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_ready", data_ready, 1);
    chk("start_err_clr", op_err, 0);
    chk("start_opdec_clr", OpDec, 0);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    logic hs;
    hs = 1'b0;
    data_valid = 1'b0;
    repeat (gap) begin
      data_in = 8'($urandom);
      tick();
    end
    data_in = b;
    data_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      hs = data_ready;
      tick();
      if (hs) break;
    end
    data_valid = 1'b0;
    chk("handshake", hs, 1);
  endtask

  task automatic txn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op, input int gap);
    int k;
    logic seen;
    start_pulse();
    start = 1'($urandom);
    send(a, gap);
    m_a = a;
    chk("A", A, m_a);
    send(b, gap);
    m_b = b;
    chk("B", B, m_b);
    send({4'($urandom), op}, gap);
    start = 1'b0;
    if (op < 9) begin
      m_opdec = onehot(int'(op));
      chk("opdec", OpDec, m_opdec);
      chk("busy_drive", busy, 1);
      k = 0;
      for (int i = 1; i <= 12; i++) begin
        tick();
        if (done) begin
          k = i;
          break;
        end
      end
      chk("done_latency", k, 4);
      m_cnt = (m_cnt + 1) % 256;
      chk("op_count", op_count, m_cnt);
      tick();
      chk("done_pulse", done, 0);
      chk("idle_busy", busy, 0);
      chk("opdec_hold", OpDec, m_opdec);
    end else begin
      m_opdec = '0;
      chk("op_err", op_err, 1);
      chk("opdec_illegal", OpDec, 0);
      chk("busy_illegal", busy, 0);
      seen = 1'b0;
      repeat (6) begin
        tick();
        seen |= done;
      end
      chk("no_done_illegal", seen, 0);
      chk("op_count_illegal", op_count, m_cnt);
    end
  endtask

  initial begin
    logic seen;
    n_chk = 0; n_pass = 0;
    m_a = '0; m_b = '0; m_opdec = '0; m_cnt = 0;
    reset_n = 1'b1; start = 1'b0; abort = 1'b0; data_valid = 1'b0; data_in = '0;
    #2 reset_n = 1'b0;
    #1 chk("reset", {data_ready, busy, done, op_err, A, B, OpDec, op_count}, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    txn(8'h35, 8'h0C, 4'h4, 0);
    txn(8'h11, 8'h22, 4'hB, 0);
    txn(8'h35, 8'h0C, 4'h4, 3);

    data_valid = 1'b1;
    data_in = 8'hFF;
    repeat (3) tick();
    data_valid = 1'b0;
    chk("idle_valid_ignored", A, m_a);

    start_pulse();
    send(8'h5A, 0);
    m_a = 8'h5A;
    data_in = 8'h99;
    data_valid = 1'b1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    data_valid = 1'b0;
    m_opdec = '0;
    chk("abort_b_not_loaded", B, m_b);
    chk("abort_b_busy", busy, 0);
    chk("abort_b_ready", data_ready, 0);
    chk("abort_b_opdec", OpDec, 0);

    txn(8'($urandom), 8'($urandom), 4'd2, 0);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    m_opdec = '0;
    chk("start_abort_busy", busy, 0);
    chk("start_abort_opdec", OpDec, 0);

    for (int j = 0; j < 4; j++) begin
      start_pulse();
      m_a = 8'($urandom);
      send(m_a, 0);
      m_b = 8'($urandom);
      send(m_b, 0);
      send(8'h07, 0);
      chk("abort_drive_pre", OpDec, onehot(7));
      seen = 1'b0;
      repeat (j) begin
        tick();
        seen |= done;
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      seen |= done;
      m_opdec = '0;
      chk("abort_drive_opdec", OpDec, 0);
      chk("abort_drive_busy", busy, 0);
      repeat (3) begin
        tick();
        seen |= done;
      end
      chk("abort_drive_no_done", seen, 0);
      chk("abort_drive_count", op_count, m_cnt);
    end

    for (int i = 0; i < 40; i++)
      txn(8'($urandom), 8'($urandom), 4'($urandom), $urandom_range(0, 3));

    start_pulse();
    send(8'($urandom), 0);
    send(8'($urandom), 0);
    send(8'h08, 0);
    chk("rst_pre_opdec", OpDec, 16'h0100);
    tick();
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1 chk("async_reset", {data_ready, busy, done, op_err, A, B, OpDec, op_count}, 0);
    m_a = '0; m_b = '0; m_opdec = '0; m_cnt = 0;
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 256; i++) begin
      txn(8'($urandom), 8'($urandom), i == 255 ? 4'd8 : 4'($urandom_range(0, 8)), 0);
      if (i == 254) chk("count_255", op_count, 255);
    end
    chk("count_wrap", op_count, 0);
    chk("wrap_opdec8", OpDec, 16'h0100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
